// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: memory-arbiter state encoding and requester codes.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

endpackage

// File: rtl/mux2.sv
// Team 32-bit 2:1 multiplexer: sel=0 passes a, sel=1 passes b.
module mux2 (
    input  logic        sel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the single memory port between instruction fetch
// and load/store; every output is driven straight from a register.
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        owner
);

    arb_state_t  state;
    arb_state_t  next_state;
    logic        grant_valid;
    logic        grant;
    logic        grant_we;
    logic        last_served;
    logic [2:0]  cnt;
    logic [31:0] rdata;
    logic [31:0] sel_addr;

    mux2 u_addr_mux (
        .sel (grant),
        .a   (if_addr),
        .b   (dm_addr),
        .y   (sel_addr)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // On a tie the requester that was not served most recently wins.
    always_comb begin
        next_state  = state;
        grant_valid = 1'b0;
        grant       = OWN_IF;
        case (state)
            IDLE: begin
                if (if_req && dm_req) begin
                    grant_valid = 1'b1;
                    grant       = (last_served == OWN_DM) ? OWN_IF : OWN_DM;
                end else if (if_req) begin
                    grant_valid = 1'b1;
                    grant       = OWN_IF;
                end else if (dm_req) begin
                    grant_valid = 1'b1;
                    grant       = OWN_DM;
                end
                if (grant_valid) begin
                    next_state = ISSUE;
                end
            end
            ISSUE:   next_state = WAIT;
            WAIT:    if (cnt == 3'd1) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        grant_we = (grant == OWN_DM) && dm_we;
    end

    // The strobe and ready pulses are set one edge early so they appear in
    // the ISSUE and DONE cycles while still coming out of flops.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rdata       <= '0;
            if_ready    <= 1'b0;
            dm_ready    <= 1'b0;
            owner       <= OWN_IF;
            last_served <= OWN_DM;
            cnt         <= '0;
        end else begin
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner     <= grant;
                        mem_addr  <= sel_addr;
                        mem_wdata <= (grant == OWN_DM) ? dm_wdata : 32'd0;
                        mem_en    <= 1'b1;
                        mem_we    <= grant_we;
                    end
                end
                ISSUE: cnt <= 3'(MEM_LATENCY);
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        rdata    <= mem_rdata;
                        if_ready <= (owner == OWN_IF);
                        dm_ready <= (owner == OWN_DM);
                    end
                end
                DONE: last_served <= owner;
                default: ;
            endcase
        end
    end

    assign if_rdata = rdata;
    assign dm_rdata = rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at latency 1, one at latency 4,
// each backed by a memory model that drives valid data only in the cycle it is due.
module tb_mem_port_arbiter;

    localparam int LAT_A = 1;
    localparam int LAT_B = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;

    logic [31:0] if_rdata_a, dm_rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
    logic        if_ready_a, dm_ready_a, mem_en_a, mem_we_a, owner_a;
    logic [31:0] if_rdata_b, dm_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
    logic        if_ready_b, dm_ready_b, mem_en_b, mem_we_b, owner_b;

    int check_count = 0;
    int pass_count  = 0;

    logic        o_en, o_we, o_ifr, o_dmr, o_owner;
    logic [31:0] o_addr, o_wdata, o_if_rdata, o_dm_rdata;

    int          cd_a, cd_b;
    logic [31:0] lat_a, lat_b;

    always #5 clock = ~clock;

    mem_port_arbiter #(.MEM_LATENCY(LAT_A)) dut_a (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_a), .if_ready(if_ready_a),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata_a), .dm_ready(dm_ready_a),
        .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a), .owner(owner_a)
    );

    mem_port_arbiter #(.MEM_LATENCY(LAT_B)) dut_b (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_b), .if_ready(if_ready_b),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata_b), .dm_ready(dm_ready_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b), .owner(owner_b)
    );

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        case (a)
            32'h0000_0040: return 32'h2008_0005;
            32'h0000_0200: return 32'h1234_5678;
            default:       return a ^ 32'hA5A5_0000;
        endcase
    endfunction

    // Memory models: data is valid only in the cycle exactly LAT cycles after mem_en.
    always @(posedge clock) begin
        if (reset) begin
            cd_a <= 0;
        end else if (mem_en_a) begin
            cd_a  <= LAT_A;
            lat_a <= mem_addr_a;
        end else if (cd_a > 0) begin
            cd_a <= cd_a - 1;
        end
    end

    always @(posedge clock) begin
        if (reset) begin
            cd_b <= 0;
        end else if (mem_en_b) begin
            cd_b  <= LAT_B;
            lat_b <= mem_addr_b;
        end else if (cd_b > 0) begin
            cd_b <= cd_b - 1;
        end
    end

    assign mem_rdata_a = (cd_a == 1) ? mem_data(lat_a) : 32'hBAD0_BAD0;
    assign mem_rdata_b = (cd_b == 1) ? mem_data(lat_b) : 32'hBAD0_BAD0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            pass_count++;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic observe(input bit use_b);
        o_en       = use_b ? mem_en_b    : mem_en_a;
        o_we       = use_b ? mem_we_b    : mem_we_a;
        o_addr     = use_b ? mem_addr_b  : mem_addr_a;
        o_wdata    = use_b ? mem_wdata_b : mem_wdata_a;
        o_ifr      = use_b ? if_ready_b  : if_ready_a;
        o_dmr      = use_b ? dm_ready_b  : dm_ready_a;
        o_owner    = use_b ? owner_b     : owner_a;
        o_if_rdata = use_b ? if_rdata_b  : if_rdata_a;
        o_dm_rdata = use_b ? dm_rdata_b  : dm_rdata_a;
    endtask

    task automatic applyStimulus_reset();
        reset    = 1'b1;
        if_req   = 1'b0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        if_addr  = '0;
        dm_addr  = '0;
        dm_wdata = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ready_at, en_n, if_n, dm_n;

        // Reset state, then a single IF fetch at latency 1.
        applyStimulus_reset();
        observe(0);
        checkOutput("rst_mem_en",   {31'd0, o_en},    32'd0);
        checkOutput("rst_mem_we",   {31'd0, o_we},    32'd0);
        checkOutput("rst_mem_addr", o_addr,           32'd0);
        checkOutput("rst_wdata",    o_wdata,          32'd0);
        checkOutput("rst_if_ready", {31'd0, o_ifr},   32'd0);
        checkOutput("rst_dm_ready", {31'd0, o_dmr},   32'd0);
        checkOutput("rst_owner",    {31'd0, o_owner}, 32'd0);
        checkOutput("rst_rdata",    o_if_rdata,       32'd0);

        if_addr = 32'h0000_0040;
        if_req  = 1'b1;
        ready_at = -1; en_n = 0; if_n = 0; dm_n = 0;
        for (int t = 1; t <= 6; t++) begin
            tick();
            observe(0);
            if (t == 1) begin
                checkOutput("if_issue_addr", o_addr, 32'h0000_0040);
                checkOutput("if_issue_we", {31'd0, o_we}, 32'd0);
            end
            if (o_en) en_n++;
            if (o_dmr) dm_n++;
            if (o_ifr) begin
                if_n++;
                if (ready_at < 0) begin
                    ready_at = t;
                    checkOutput("if_rdata", o_if_rdata, 32'h2008_0005);
                    if_req = 1'b0;
                end
            end
        end
        checkOutput("if_ready_cycle", 32'(ready_at), 32'd3);
        checkOutput("if_en_count", 32'(en_n), 32'd1);
        checkOutput("if_ready_count", 32'(if_n), 32'd1);
        checkOutput("if_no_dm_ready", 32'(dm_n), 32'd0);

        // DM store at latency 1.
        applyStimulus_reset();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0100; dm_wdata = 32'hDEAD_BEEF;
        ready_at = -1; en_n = 0; dm_n = 0;
        for (int t = 1; t <= 6; t++) begin
            tick();
            observe(0);
            if (t == 1) begin
                checkOutput("st_mem_we", {31'd0, o_we}, 32'd1);
                checkOutput("st_wdata", o_wdata, 32'hDEAD_BEEF);
                checkOutput("st_addr", o_addr, 32'h0000_0100);
                checkOutput("st_owner", {31'd0, o_owner}, 32'd1);
            end
            if (!o_en && o_we) checkOutput("st_we_without_en", {31'd0, o_we}, 32'd0);
            if (o_en) en_n++;
            if (o_dmr) begin
                dm_n++;
                if (ready_at < 0) ready_at = t;
                dm_req = 1'b0;
            end
        end
        checkOutput("st_ready_cycle", 32'(ready_at), 32'd3);
        checkOutput("st_en_count", 32'(en_n), 32'd1);
        checkOutput("st_ready_count", 32'(dm_n), 32'd1);

        // Both requesters held: grants alternate IF, DM, IF, DM every 4 cycles.
        applyStimulus_reset();
        if_addr = 32'h0000_0010; dm_addr = 32'h0000_0020; dm_we = 1'b0;
        if_req = 1'b1; dm_req = 1'b1;
        en_n = 0; if_n = 0; dm_n = 0;
        for (int t = 1; t <= 15; t++) begin
            tick();
            observe(0);
            if (o_en) begin
                checkOutput($sformatf("rr_issue_cycle%0d", en_n), 32'(t), 32'(1 + 4 * en_n));
                checkOutput($sformatf("rr_owner%0d", en_n), {31'd0, o_owner}, 32'(en_n % 2));
                checkOutput($sformatf("rr_addr%0d", en_n), o_addr,
                            (en_n % 2 != 0) ? 32'h0000_0020 : 32'h0000_0010);
                en_n++;
            end
            if (o_ifr) if_n++;
            if (o_dmr) dm_n++;
            if (t == 15) begin
                if_req = 1'b0;
                dm_req = 1'b0;
            end
        end
        checkOutput("rr_en_count", 32'(en_n), 32'd4);
        checkOutput("rr_if_ready_count", 32'(if_n), 32'd2);
        checkOutput("rr_dm_ready_count", 32'(dm_n), 32'd2);

        // DM load at latency 4.
        applyStimulus_reset();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0200;
        ready_at = -1; en_n = 0; if_n = 0; dm_n = 0;
        for (int t = 1; t <= 9; t++) begin
            tick();
            observe(1);
            if (t == 1) checkOutput("l4_issue_addr", o_addr, 32'h0000_0200);
            if (o_en) en_n++;
            if (o_ifr) if_n++;
            if (o_dmr) begin
                dm_n++;
                if (ready_at < 0) begin
                    ready_at = t;
                    checkOutput("l4_dm_rdata", o_dm_rdata, 32'h1234_5678);
                end
                dm_req = 1'b0;
            end
        end
        checkOutput("l4_ready_cycle", 32'(ready_at), 32'd6);
        checkOutput("l4_en_count", 32'(en_n), 32'd1);
        checkOutput("l4_ready_count", 32'(dm_n), 32'd1);
        checkOutput("l4_no_if_ready", 32'(if_n), 32'd0);

        // Reset during WAIT (latency 4 store), then a tie grants IF first.
        applyStimulus_reset();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0300; dm_wdata = 32'h55AA_55AA;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        observe(1);
        checkOutput("wr_mem_en",   {31'd0, o_en},    32'd0);
        checkOutput("wr_mem_we",   {31'd0, o_we},    32'd0);
        checkOutput("wr_mem_addr", o_addr,           32'd0);
        checkOutput("wr_wdata",    o_wdata,          32'd0);
        checkOutput("wr_dm_ready", {31'd0, o_dmr},   32'd0);
        checkOutput("wr_if_ready", {31'd0, o_ifr},   32'd0);
        checkOutput("wr_owner",    {31'd0, o_owner}, 32'd0);
        reset = 1'b0;
        if_addr = 32'h0000_0044; if_req = 1'b1; dm_we = 1'b0;
        en_n = 0; if_n = 0; dm_n = 0;
        for (int t = 1; t <= 7; t++) begin
            tick();
            observe(1);
            if (t == 1) begin
                checkOutput("wr_tie_owner", {31'd0, o_owner}, 32'd0);
                checkOutput("wr_tie_addr", o_addr, 32'h0000_0044);
            end
            if (o_en) en_n++;
            if (o_ifr) if_n++;
            if (o_dmr) dm_n++;
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        checkOutput("wr_en_count", 32'(en_n), 32'd1);
        checkOutput("wr_if_ready_count", 32'(if_n), 32'd1);
        checkOutput("wr_dm_ready_count", 32'(dm_n), 32'd0);

        // dm_req dropped during ISSUE still completes exactly once.
        applyStimulus_reset();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0180;
        tick();
        observe(0);
        checkOutput("drop_issue_en", {31'd0, o_en}, 32'd1);
        dm_req = 1'b0;
        ready_at = -1; en_n = 0; dm_n = 0;
        for (int t = 2; t <= 8; t++) begin
            tick();
            observe(0);
            if (o_en) en_n++;
            if (o_dmr) begin
                dm_n++;
                if (ready_at < 0) begin
                    ready_at = t;
                    checkOutput("drop_rdata", o_dm_rdata, 32'hA5A5_0180);
                end
            end
        end
        checkOutput("drop_ready_cycle", 32'(ready_at), 32'd3);
        checkOutput("drop_ready_count", 32'(dm_n), 32'd1);
        checkOutput("drop_no_reissue", 32'(en_n), 32'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares the single memory port of the MIPS core between the instruction-fetch requester (IF) and the load/store requester (DM). It grants the port round-robin, registers and drives address/write data/write enable to memory for one issue cycle, waits a fixed memory latency, captures read data, and returns a one-cycle ready pulse to the granted requester. It sits between the fetch/load-store logic and the memory, and replaces the direct instruction/data memory wiring when the core moves to a shared-memory configuration.

## Interface
- MEM_LATENCY, 1, cycles from the issue cycle to valid mem_rdata; legal range 1–4
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held high until if_ready
- if_addr  in  32  fetch address
- if_rdata  out  32  fetched word, valid while if_ready=1
- if_ready  out  1  one-cycle completion pulse for IF
- dm_req  in  1  data request; held high until dm_ready
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  32  data address
- dm_wdata  in  32  store data
- dm_rdata  out  32  load data, valid while dm_ready=1
- dm_ready  out  1  one-cycle completion pulse for DM
- mem_en  out  1  memory access strobe, high exactly one cycle per access
- mem_we  out  1  memory write enable, only ever high together with mem_en
- mem_addr  out  32  registered memory address
- mem_wdata  out  32  registered memory write data
- mem_rdata  in  32  memory read data, valid MEM_LATENCY cycles after mem_en
- owner  out  1  current/last grant: 0 = IF, 1 = DM

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: arbitrate at each rising edge. Only one req high → grant it. Both high → grant the requester not served last (last_served register). Neither → stay in IDLE.
- On grant: owner, mem_addr, mem_wdata (DM only; IF grant loads 0), and the write flag (dm_we for DM, 0 for IF) are registered; go to ISSUE.
- ISSUE: mem_en=1, mem_we=write flag; load the latency counter with MEM_LATENCY; go to WAIT.
- WAIT: decrement the counter each cycle. In the cycle where the counter reaches 1, mem_rdata is valid; capture it into the rdata register at that edge and go to DONE.
- DONE: assert the owner's ready for one cycle; the other requester's ready stays 0. Update last_served=owner; go to IDLE.
- if_rdata and dm_rdata both present the shared rdata register; they are meaningful only while the matching ready is high.
- Stores also wait the full latency and pulse dm_ready; the rdata value captured for a store is don't-care.
- A req dropped mid-access does not abort it: the access completes and the ready pulse is still issued.
- Requests are sampled only in IDLE; req/address changes in ISSUE, WAIT or DONE are ignored.
- Reset (any state, including mid-access): state=IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, if_ready=0, dm_ready=0, owner=0, last_served=1 (DM), so IF wins the first tie.

## Timing
- Request sampled at edge E0 → ISSUE in cycle E0+1 → mem_rdata captured at the end of cycle E0+1+MEM_LATENCY → ready high in cycle E0+2+MEM_LATENCY.
- For MEM_LATENCY=1, ready is high 3 cycles after the sampling edge; the total occupancy per access is MEM_LATENCY+3 cycles, including the return to IDLE.
- The requester must deassert req by the edge that ends its ready cycle. A req still high at the next IDLE sample is treated as a new request.
- All outputs are registered. No combinational path exists from any input to any output.

## Structure
- A shared package (mips_pkg) holds the state encoding constants (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DONE=2'd3) and the owner codes OWN_IF=1'b0 and OWN_DM=1'b1.
- Address selection uses one sub-module: mux2, the team's 32-bit 2:1 multiplexer, with sel=grant, A=if_addr, B=dm_addr. Its output feeds the mem_addr register.
- The latency counter is 3 bits wide, which covers MEM_LATENCY up to 4.

## Test plan
- Reset then single IF request: MEM_LATENCY=1, if_addr=0x0000_0040, memory returns 0x2008_0005 → mem_en one cycle with mem_addr=0x40 and mem_we=0, if_ready exactly 3 cycles after the sampling edge, if_rdata=0x2008_0005, dm_ready stays 0.
- DM store: dm_we=1, dm_addr=0x100, dm_wdata=0xDEAD_BEEF → one mem_en with mem_we=1 and mem_wdata=0xDEAD_BEEF, followed by a single dm_ready pulse.
- Simultaneous requests held continuously: after reset, grants alternate IF, DM, IF, DM; owner toggles; each access takes MEM_LATENCY+3 cycles.
- MEM_LATENCY=4 DM load from 0x200, memory returns 0x1234_5678 → dm_ready 6 cycles after the sampling edge with dm_rdata=0x1234_5678; mem_en is never re-asserted during WAIT.
- Reset asserted in WAIT: the next cycle shows all outputs at their reset values with no ready pulse; a following simultaneous request grants IF first.
- dm_req dropped in ISSUE → the access still completes with one dm_ready pulse; nothing is re-issued afterwards.
